// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank: RW control registers, RO status registers, SLVERR on unmapped words.
// Optional maskable interrupt block (IRQ_STATUS W1C + IRQ_ENABLE) enabled by defining AXILITE_REGBANK_IRQ_EN.
module axi_lite_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_RW = 4,
  parameter int NUM_RO = 2,
  parameter int IRQ_WIDTH = 8,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                                s00_axi_aclk,
  input  logic                                s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       s00_axi_awaddr,
  input  logic [2:0]                          s00_axi_awprot,
  input  logic                                s00_axi_awvalid,
  output logic                                s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     s00_axi_wstrb,
  input  logic                                s00_axi_wvalid,
  output logic                                s00_axi_wready,
  output logic [1:0]                          s00_axi_bresp,
  output logic                                s00_axi_bvalid,
  input  logic                                s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       s00_axi_araddr,
  input  logic [2:0]                          s00_axi_arprot,
  input  logic                                s00_axi_arvalid,
  output logic                                s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       s00_axi_rdata,
  output logic [1:0]                          s00_axi_rresp,
  output logic                                s00_axi_rvalid,
  input  logic                                s00_axi_rready,
  output logic [NUM_RW*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [NUM_RW-1:0]                   reg_wr_pulse,
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*C_S_AXI_DATA_WIDTH-1:0] status_in,
  input  logic [IRQ_WIDTH-1:0]                irq_src,
  output logic                                irq
);
  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int SW       = DW / 8;
  localparam int ADDR_LSB = $clog2(SW);
  localparam int IW       = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
`ifdef AXILITE_REGBANK_IRQ_EN
  localparam int NUM_IDX  = NUM_RW + NUM_RO + 2;
`else
  localparam int NUM_IDX  = NUM_RW + NUM_RO;
`endif
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_v,
                                               input logic [DW-1:0] new_v,
                                               input logic [SW-1:0] strb);
    logic [DW-1:0] r;
    r = old_v;
    for (int b = 0; b < SW; b++)
      if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  logic          aw_held, w_held;
  logic [IW-1:0] aw_idx_q;
  logic [DW-1:0] w_data_q;
  logic [SW-1:0] w_strb_q;
  logic          aw_hs, w_hs, ar_hs, commit, wr_oor;
  logic [IW-1:0] aw_idx_in, ar_idx, wr_idx;
  logic [DW-1:0] wr_data, rd_data;
  logic [SW-1:0] wr_strb;
  logic          rd_err;
  logic [DW-1:0] regs [NUM_RW];

  assign aw_idx_in = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign ar_idx    = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];

  assign s00_axi_awready = !aw_held && !s00_axi_bvalid;
  assign s00_axi_wready  = !w_held && !s00_axi_bvalid;
  assign s00_axi_arready = !s00_axi_rvalid;

  assign aw_hs = s00_axi_awvalid && s00_axi_awready;
  assign w_hs  = s00_axi_wvalid && s00_axi_wready;
  assign ar_hs = s00_axi_arvalid && s00_axi_arready;

  // A channel handshaking this cycle counts as held, so a write can commit the same edge its last half arrives.
  assign commit  = (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_idx  = aw_held ? aw_idx_q : aw_idx_in;
  assign wr_data = w_held ? w_data_q : s00_axi_wdata;
  assign wr_strb = w_held ? w_strb_q : s00_axi_wstrb;
  assign wr_oor  = int'(wr_idx) >= NUM_IDX;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) aw_held <= 1'b1;
      if (w_hs)  w_held  <= 1'b1;
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (aw_hs) aw_idx_q <= aw_idx_in;
    if (w_hs) begin
      w_data_q <= s00_axi_wdata;
      w_strb_q <= s00_axi_wstrb;
    end
  end

  // ---- commit stage: register update, write pulse and B response ----
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      for (int k = 0; k < NUM_RW; k++) regs[k] <= RESET_VALUE;
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      for (int k = 0; k < NUM_RW; k++) begin
        if (commit && int'(wr_idx) == k) begin
          regs[k]         <= apply_strb(regs[k], wr_data, wr_strb);
          reg_wr_pulse[k] <= |wr_strb;
        end
      end
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      s00_axi_bvalid <= 1'b0;
      s00_axi_bresp  <= RESP_OKAY;
    end else if (commit) begin
      s00_axi_bvalid <= 1'b1;
      s00_axi_bresp  <= wr_oor ? RESP_SLVERR : RESP_OKAY;
    end else if (s00_axi_bvalid && s00_axi_bready) begin
      s00_axi_bvalid <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_RW; g++) begin : g_reg_out
    assign reg_out[g*DW +: DW] = regs[g];
  end

`ifdef AXILITE_REGBANK_IRQ_EN
  logic [IRQ_WIDTH-1:0] irq_status, irq_enable, irq_clr, en_next;
  logic [DW-1:0]        clr_full, en_full;

  always_comb begin
    clr_full = '0;
    if (commit && int'(wr_idx) == NUM_RW + NUM_RO)
      clr_full = apply_strb('0, wr_data, wr_strb);
    en_full  = apply_strb(DW'(irq_enable), wr_data, wr_strb);
    irq_clr  = clr_full[IRQ_WIDTH-1:0];
    en_next  = en_full[IRQ_WIDTH-1:0];
  end

  // Setting is ORed in after clearing so a live source wins over a W1C in the same cycle.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      irq_status <= '0;
      irq_enable <= '0;
      irq        <= 1'b0;
    end else begin
      irq_status <= (irq_status & ~irq_clr) | irq_src;
      if (commit && int'(wr_idx) == NUM_RW + NUM_RO + 1) irq_enable <= en_next;
      irq        <= |(irq_status & irq_enable);
    end
  end
`else
  assign irq = 1'b0;
  wire unused_irq_src = ^irq_src;
`endif

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b1;
    for (int k = 0; k < NUM_RW; k++)
      if (int'(ar_idx) == k) begin
        rd_data = regs[k];
        rd_err  = 1'b0;
      end
    for (int k = 0; k < NUM_RO; k++)
      if (int'(ar_idx) == NUM_RW + k) begin
        rd_data = status_in[k*DW +: DW];
        rd_err  = 1'b0;
      end
`ifdef AXILITE_REGBANK_IRQ_EN
    if (int'(ar_idx) == NUM_RW + NUM_RO) begin
      rd_data = DW'(irq_status);
      rd_err  = 1'b0;
    end
    if (int'(ar_idx) == NUM_RW + NUM_RO + 1) begin
      rd_data = DW'(irq_enable);
      rd_err  = 1'b0;
    end
`endif
  end

  // ---- read stage: data captured at the AR handshake, held until rready ----
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      s00_axi_rvalid <= 1'b0;
      s00_axi_rdata  <= '0;
      s00_axi_rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      s00_axi_rvalid <= 1'b1;
      s00_axi_rdata  <= rd_data;
      s00_axi_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (s00_axi_rvalid && s00_axi_rready) begin
      s00_axi_rvalid <= 1'b0;
    end
  end

  wire unused_bits = ^{s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[ADDR_LSB-1:0], s00_axi_araddr[ADDR_LSB-1:0]};
endmodule
